// File: rtl/clock_set_ctrl.sv
// Time-setting and count-enable controller for the 24-hour clock: debounced
// MODE/SET buttons, RUN/SET_HOUR/SET_MIN mode FSM, auto-repeat and blink.

module clock_set_ctrl_debounce #(
    parameter int DEB_CNT = 20000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic level
);
    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            // The level flips on the cycle the counter would reach DEB_CNT.
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
endmodule

module clock_set_ctrl #(
    parameter int DEB_CNT = 20000,
    parameter int RPT_DLY = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SEC_TICK,
    input  logic       HALF_TICK,
    input  logic       MODE_BTN,
    input  logic       SET_BTN,
    input  logic       SEC_CO,
    input  logic       MIN_CO,
    output logic       SEC_EN,
    output logic       SEC_CLR,
    output logic       MIN_EN,
    output logic       MIN_INC,
    output logic       HOUR_EN,
    output logic       HOUR_INC,
    output logic [1:0] MODE,
    output logic       BLINK_H,
    output logic       BLINK_M
);
    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    localparam int RW = $clog2(RPT_DLY + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(RPT_DLY);

    logic          mode_level, set_level;
    logic          mode_dly_q, mode_dly_d;
    logic          set_dly_q, set_dly_d;
    logic          mode_press, set_press;
    mode_e         mode_q, mode_d;
    logic          armed_q, armed_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          inc_hour_q, inc_hour_d;
    logic          inc_min_q, inc_min_d;
    logic          sec_clr_q, sec_clr_d;
    logic          blink_q, blink_d;
    logic          in_set, rpt_fire, inc_evt;

    clock_set_ctrl_debounce #(.DEB_CNT(DEB_CNT)) u_mode_deb (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (MODE_BTN),
        .level   (mode_level)
    );

    clock_set_ctrl_debounce #(.DEB_CNT(DEB_CNT)) u_set_deb (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (SET_BTN),
        .level   (set_level)
    );

    // Mode FSM: state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state, advanced only by a MODE press.
    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_d = MODE_SET_MIN;
                default:       mode_d = MODE_RUN;
            endcase
        end
    end

    // Press detection, auto-repeat, INC/CLR pulses and blink phase.
    always_comb begin
        mode_dly_d = mode_level;
        set_dly_d  = set_level;
        mode_press = mode_level & ~mode_dly_q;
        set_press  = set_level & ~set_dly_q;
        in_set     = (mode_q != MODE_RUN);
        rpt_fire   = armed_q & set_level & HALF_TICK & (rpt_cnt_q == RPT_LAST);
        // A MODE press swallows any SET event in the same cycle.
        inc_evt    = in_set & ~mode_press & (set_press | rpt_fire);

        armed_d   = armed_q;
        rpt_cnt_d = rpt_cnt_q;
        if (mode_press || !set_level) begin
            armed_d   = 1'b0;
            rpt_cnt_d = '0;
        end else if (set_press) begin
            armed_d   = in_set;
            rpt_cnt_d = '0;
        end else if (armed_q && HALF_TICK && (rpt_cnt_q != RPT_LAST)) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
        end

        inc_hour_d = inc_evt & (mode_q == MODE_SET_HOUR);
        inc_min_d  = inc_evt & (mode_q == MODE_SET_MIN);
        sec_clr_d  = mode_press & (mode_q == MODE_SET_MIN);

        blink_d = blink_q;
        if (mode_press || inc_evt) begin
            blink_d = 1'b1;
        end else if (HALF_TICK) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_dly_q <= 1'b0;
            set_dly_q  <= 1'b0;
            armed_q    <= 1'b0;
            rpt_cnt_q  <= '0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            sec_clr_q  <= 1'b0;
            blink_q    <= 1'b1;
        end else begin
            mode_dly_q <= mode_dly_d;
            set_dly_q  <= set_dly_d;
            armed_q    <= armed_d;
            rpt_cnt_q  <= rpt_cnt_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
            sec_clr_q  <= sec_clr_d;
            blink_q    <= blink_d;
        end
    end

    // Mode FSM: outputs. The SEC_CLR cycle blocks the carry chain.
    always_comb begin
        SEC_EN   = 1'b0;
        MIN_EN   = 1'b0;
        HOUR_EN  = 1'b0;
        BLINK_H  = 1'b1;
        BLINK_M  = 1'b1;
        MODE     = mode_q;
        SEC_CLR  = sec_clr_q;
        MIN_INC  = inc_min_q;
        HOUR_INC = inc_hour_q;
        case (mode_q)
            MODE_RUN: begin
                if (!sec_clr_q) begin
                    SEC_EN  = SEC_TICK;
                    MIN_EN  = SEC_TICK & SEC_CO;
                    HOUR_EN = SEC_TICK & SEC_CO & MIN_CO;
                end
            end
            MODE_SET_HOUR: BLINK_H = blink_q;
            MODE_SET_MIN:  BLINK_M = blink_q;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DEB_CNT=4, RPT_DLY=2; INC pulses are
// matched against a queue of expected pulses filled as buttons are driven.

module tb_clock_set_ctrl;
    localparam int DEB_CNT = 4;
    localparam int RPT_DLY = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SEC_TICK = 1'b0;
    logic       HALF_TICK = 1'b0;
    logic       MODE_BTN = 1'b0;
    logic       SET_BTN = 1'b0;
    logic       SEC_CO = 1'b0;
    logic       MIN_CO = 1'b0;
    logic       SEC_EN, SEC_CLR, MIN_EN, MIN_INC, HOUR_EN, HOUR_INC;
    logic [1:0] MODE;
    logic       BLINK_H, BLINK_M;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int hour_pulses = 0;
    int min_pulses = 0;
    logic [1:0] inc_exp_q[$];
    logic [1:0] exp_inc;

    clock_set_ctrl #(.DEB_CNT(DEB_CNT), .RPT_DLY(RPT_DLY)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SEC_TICK  (SEC_TICK),
        .HALF_TICK (HALF_TICK),
        .MODE_BTN  (MODE_BTN),
        .SET_BTN   (SET_BTN),
        .SEC_CO    (SEC_CO),
        .MIN_CO    (MIN_CO),
        .SEC_EN    (SEC_EN),
        .SEC_CLR   (SEC_CLR),
        .MIN_EN    (MIN_EN),
        .MIN_INC   (MIN_INC),
        .HOUR_EN   (HOUR_EN),
        .HOUR_INC  (HOUR_INC),
        .MODE      (MODE),
        .BLINK_H   (BLINK_H),
        .BLINK_M   (BLINK_M)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
        n_checks++;
        assert (obs === exp_val) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Scoreboard side: every INC pulse cycle pops one expected {HOUR_INC, MIN_INC}.
    always @(negedge CLK) begin
        if (HOUR_INC || MIN_INC) begin
            if (inc_exp_q.size() > 0) exp_inc = inc_exp_q.pop_front();
            else exp_inc = 2'b00;
            check("inc_pulse", 8'({HOUR_INC, MIN_INC}), 8'(exp_inc));
            check("inc_blink", 8'({BLINK_H, BLINK_M}), 8'h03);
            check("inc_frozen", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h00);
            if (HOUR_INC) hour_pulses++;
            if (MIN_INC) min_pulses++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        // Reset state, sampled mid-cycle while RST is high.
        #12;
        check("rst_mode", 8'(MODE), 8'h00);
        check("rst_pulses", 8'({SEC_CLR, MIN_INC, HOUR_INC}), 8'h00);
        check("rst_blink", 8'({BLINK_H, BLINK_M}), 8'h03);
        @(posedge CLK); #1;
        RST = 1'b0;
        step(2);

        // Bouncy MODE: 3 high, 1 low, 1 high, then low -> no mode change.
        MODE_BTN = 1'b1; step(3);
        MODE_BTN = 1'b0; step(1);
        MODE_BTN = 1'b1; step(1);
        MODE_BTN = 1'b0; step(12);
        @(negedge CLK);
        check("bounce_mode", 8'(MODE), 8'h00);

        // RUN carry chain.
        step(1); SEC_CO = 1'b1; MIN_CO = 1'b1; SEC_TICK = 1'b1;
        @(negedge CLK);
        check("run_all_carry", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h07);
        check("run_blink", 8'({BLINK_H, BLINK_M}), 8'h03);
        step(1); SEC_TICK = 1'b0;
        @(negedge CLK);
        check("run_idle", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h00);
        step(1); MIN_CO = 1'b0; SEC_TICK = 1'b1;
        @(negedge CLK);
        check("run_no_hour", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h06);
        step(1); SEC_CO = 1'b0;
        @(negedge CLK);
        check("run_sec_only", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h04);
        step(1); SEC_TICK = 1'b0;

        // Stable MODE press: MODE changes exactly 7 CLK after the raw edge.
        MODE_BTN = 1'b1; step(6);
        @(negedge CLK);
        check("mode_edge6", 8'(MODE), 8'h00);
        step(1);
        @(negedge CLK);
        check("mode_edge7", 8'(MODE), 8'h01);
        check("blink_entry", 8'({BLINK_H, BLINK_M}), 8'h03);
        step(3); MODE_BTN = 1'b0; step(10);

        // SET_HOUR: blink toggles per HALF_TICK, time frozen.
        HALF_TICK = 1'b1; step(1); HALF_TICK = 1'b0;
        @(negedge CLK);
        check("blink_h_toggle0", 8'({BLINK_H, BLINK_M}), 8'h01);
        step(1); HALF_TICK = 1'b1; step(1); HALF_TICK = 1'b0;
        @(negedge CLK);
        check("blink_h_toggle1", 8'({BLINK_H, BLINK_M}), 8'h03);
        step(1); SEC_CO = 1'b1; MIN_CO = 1'b1; SEC_TICK = 1'b1;
        @(negedge CLK);
        check("set_hour_frozen", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h00);
        step(1); SEC_TICK = 1'b0;

        // Three separate SET presses -> three HOUR_INC pulses.
        for (int i = 0; i < 3; i++) begin
            HALF_TICK = 1'b1; step(1); HALF_TICK = 1'b0;
            @(negedge CLK);
            check("blink_h_pre_inc", 8'(BLINK_H), 8'h00);
            step(1);
            inc_exp_q.push_back(2'b10);
            SET_BTN = 1'b1; step(8);
            SET_BTN = 1'b0; step(10);
        end
        check("hour_pulses", 8'(hour_pulses), 8'd3);
        check("hour_no_min", 8'(min_pulses), 8'd0);
        check("hour_queue_empty", 8'(inc_exp_q.size()), 8'd0);

        // Into SET_MIN.
        MODE_BTN = 1'b1; step(8); MODE_BTN = 1'b0; step(10);
        @(negedge CLK);
        check("mode_set_min", 8'(MODE), 8'h02);
        check("blink_min_entry", 8'({BLINK_H, BLINK_M}), 8'h03);

        // SET held over 6 HALF_TICKs: press INC + repeats after RPT_DLY ticks.
        step(1);
        inc_exp_q.push_back(2'b01);
        SET_BTN = 1'b1; step(9);
        for (int i = 0; i < 6; i++) begin
            if (i >= RPT_DLY) inc_exp_q.push_back(2'b01);
            HALF_TICK = 1'b1; step(1); HALF_TICK = 1'b0; step(2);
        end
        SET_BTN = 1'b0; step(10);
        for (int i = 0; i < 3; i++) begin
            HALF_TICK = 1'b1; step(1); HALF_TICK = 1'b0; step(2);
        end
        @(negedge CLK);
        check("min_pulses", 8'(min_pulses), 8'd5);
        check("min_no_hour", 8'(hour_pulses), 8'd3);
        check("min_queue_empty", 8'(inc_exp_q.size()), 8'd0);

        // SET_MIN -> RUN with SEC_TICK in the SEC_CLR cycle.
        step(1); SEC_CO = 1'b1; MIN_CO = 1'b1;
        MODE_BTN = 1'b1; step(7); SEC_TICK = 1'b1;
        @(negedge CLK);
        check("clr_mode_run", 8'(MODE), 8'h00);
        check("clr_pulse", 8'(SEC_CLR), 8'h01);
        check("clr_en_blocked", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h00);
        step(1); SEC_TICK = 1'b0; MODE_BTN = 1'b0;
        @(negedge CLK);
        check("clr_single_cycle", 8'(SEC_CLR), 8'h00);
        step(1); SEC_TICK = 1'b1;
        @(negedge CLK);
        check("tick_after_clr", 8'({SEC_EN, MIN_EN, HOUR_EN}), 8'h07);
        step(1); SEC_TICK = 1'b0; step(10);

        // Reset while in SET_HOUR with SET held and an INC pulse showing.
        MODE_BTN = 1'b1; step(8); MODE_BTN = 1'b0; step(10);
        @(negedge CLK);
        check("rst_test_mode", 8'(MODE), 8'h01);
        step(1);
        SET_BTN = 1'b1; step(7);
        #2;
        check("inc_before_rst", 8'(HOUR_INC), 8'h01);
        RST = 1'b1;
        #1;
        check("async_rst_mode", 8'(MODE), 8'h00);
        check("async_rst_inc", 8'({HOUR_INC, MIN_INC, SEC_CLR}), 8'h00);
        check("async_rst_blink", 8'({BLINK_H, BLINK_M}), 8'h03);
        step(2);
        RST = 1'b0; SET_BTN = 1'b0; step(12);
        @(negedge CLK);
        check("final_mode", 8'(MODE), 8'h00);
        check("final_hour_pulses", 8'(hour_pulses), 8'd3);
        check("final_queue_empty", 8'(inc_exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
